reg_file: RTL and testbench

- Dual-write, dual-read integer register file for a two-issue pipelined RISC-V style core.
- Holds 2^AW registers of XLEN bits each.
- Two combinational read ports (rd1/rd2) feed operand fetch.
- Two synchronous write ports (port 3 and port 4) are driven by writeback; port 4 carries the younger instruction.
- Register 0 is hardwired to zero.

---
 rtl/reg_file_if.sv | 18 +
 rtl/reg_file.sv | 33 +++
 tb/tb_reg_file.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle for the dual-write, dual-read register file
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            we3;
  logic            we4;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [AW-1:0]   wa3;
  logic [AW-1:0]   wa4;
  logic [XLEN-1:0] wd3;
  logic [XLEN-1:0] wd4;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  modport master (output we3, we4, ra1, ra2, wa3, wa4, wd3, wd4, input rd1, rd2);
  modport slave  (input we3, we4, ra1, ra2, wa3, wa4, wd3, wd4, output rd1, rd2);
endinterface

// File: rtl/reg_file.sv
// reg_file: 2-write/2-read register file with hardwired x0 and optional write-to-read bypass
module reg_file #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     reset,
  reg_file_if.slave bus
);
  localparam int N = 2 ** AW;
  logic [XLEN-1:0] mem [1:N-1];
  logic            byp;
  assign byp = (BYPASS != 0) && !reset;
  // clear on reset, else port 4 written last so it wins an address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < N; i++) mem[i] <= '0;
    end else begin
      if (bus.we3 && bus.wa3 != '0) mem[bus.wa3] <= bus.wd3;
      if (bus.we4 && bus.wa4 != '0) mem[bus.wa4] <= bus.wd4;
    end
  end
  // combinational reads: x0 forced to zero, then port 4 / port 3 forwarding, then stored value
  always_comb begin
    bus.rd1 = bus.ra1 == '0 ? '0 :
              (byp && bus.we4 && bus.wa4 == bus.ra1) ? bus.wd4 :
              (byp && bus.we3 && bus.wa3 == bus.ra1) ? bus.wd3 : mem[bus.ra1];
    bus.rd2 = bus.ra2 == '0 ? '0 :
              (byp && bus.we4 && bus.wa4 == bus.ra2) ? bus.wd4 :
              (byp && bus.we3 && bus.wa3 == bus.ra2) ? bus.wd3 : mem[bus.ra2];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks of reset, writes, collision, x0, bypass and reset priority
module tb_reg_file;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_file_if #(.XLEN(32), .AW(5)) bus ();
  reg_file_if #(.XLEN(32), .AW(5)) nb ();
  assign nb.we3 = bus.we3;
  assign nb.we4 = bus.we4;
  assign nb.ra1 = bus.ra1;
  assign nb.ra2 = bus.ra2;
  assign nb.wa3 = bus.wa3;
  assign nb.wa4 = bus.wa4;
  assign nb.wd3 = bus.wd3;
  assign nb.wd4 = bus.wd4;
  reg_file #(.XLEN(32), .AW(5), .BYPASS(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  reg_file #(.XLEN(32), .AW(5), .BYPASS(0)) dut_nb (.clk(clk), .reset(reset), .bus(nb.slave));
  task automatic idle();
    bus.we3 = 1'b0;
    bus.we4 = 1'b0;
    bus.wa3 = '0;
    bus.wa4 = '0;
    bus.wd3 = '0;
    bus.wd4 = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.ra1 = '0;
    bus.ra2 = '0;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL pre_reset_x0 got=%h exp=%h", bus.rd1, 32'h0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.ra1 = 5'(a);
      bus.ra2 = 5'(31 - a);
      #1;
      checks++;
      if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL reset_rd1[%0d] got=%h exp=%h", a, bus.rd1, 32'h0); end
      checks++;
      if (bus.rd2 !== 32'h0) begin failures++; $display("FAIL reset_rd2[%0d] got=%h exp=%h", 31 - a, bus.rd2, 32'h0); end
    end
  endtask
  task automatic test_single_write();
    bus.we3 = 1'b1;
    bus.wa3 = 5'd1;
    bus.wd3 = 32'h42424242;
    bus.ra1 = 5'd1;
    #1;
    checks++;
    if (bus.rd1 !== 32'h42424242) begin failures++; $display("FAIL single_bypass got=%h exp=%h", bus.rd1, 32'h42424242); end
    checks++;
    if (nb.rd1 !== 32'h0) begin failures++; $display("FAIL single_nobypass_pre got=%h exp=%h", nb.rd1, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h42424242) begin failures++; $display("FAIL single_after got=%h exp=%h", bus.rd1, 32'h42424242); end
    checks++;
    if (nb.rd1 !== 32'h42424242) begin failures++; $display("FAIL single_nobypass_after got=%h exp=%h", nb.rd1, 32'h42424242); end
  endtask
  task automatic test_dual_write();
    bus.we3 = 1'b1;
    bus.wa3 = 5'd1;
    bus.wd3 = 32'h42424242;
    bus.we4 = 1'b1;
    bus.wa4 = 5'd2;
    bus.wd4 = 32'hDEADBEEF;
    bus.ra1 = 5'd1;
    bus.ra2 = 5'd2;
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h42424242) begin failures++; $display("FAIL dual_rd1 got=%h exp=%h", bus.rd1, 32'h42424242); end
    checks++;
    if (bus.rd2 !== 32'hDEADBEEF) begin failures++; $display("FAIL dual_rd2 got=%h exp=%h", bus.rd2, 32'hDEADBEEF); end
    tick();
    checks++;
    if (bus.rd1 !== 32'h42424242) begin failures++; $display("FAIL dual_hold_rd1 got=%h exp=%h", bus.rd1, 32'h42424242); end
    checks++;
    if (bus.rd2 !== 32'hDEADBEEF) begin failures++; $display("FAIL dual_hold_rd2 got=%h exp=%h", bus.rd2, 32'hDEADBEEF); end
  endtask
  task automatic test_collision();
    bus.we3 = 1'b1;
    bus.wa3 = 5'd5;
    bus.wd3 = 32'h11111111;
    bus.we4 = 1'b1;
    bus.wa4 = 5'd5;
    bus.wd4 = 32'h22222222;
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd5;
    #1;
    checks++;
    if (bus.rd1 !== 32'h22222222) begin failures++; $display("FAIL collide_bypass got=%h exp=%h", bus.rd1, 32'h22222222); end
    checks++;
    if (nb.rd2 !== 32'h0) begin failures++; $display("FAIL collide_nobypass_pre got=%h exp=%h", nb.rd2, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h22222222) begin failures++; $display("FAIL collide_after_rd1 got=%h exp=%h", bus.rd1, 32'h22222222); end
    checks++;
    if (bus.rd2 !== 32'h22222222) begin failures++; $display("FAIL collide_after_rd2 got=%h exp=%h", bus.rd2, 32'h22222222); end
  endtask
  task automatic test_x0();
    bus.we3 = 1'b1;
    bus.wa3 = 5'd0;
    bus.wd3 = 32'hFFFFFFFF;
    bus.we4 = 1'b1;
    bus.wa4 = 5'd0;
    bus.wd4 = 32'hFFFFFFFF;
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd1;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL x0_during got=%h exp=%h", bus.rd1, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL x0_after got=%h exp=%h", bus.rd1, 32'h0); end
    checks++;
    if (bus.rd2 !== 32'h42424242) begin failures++; $display("FAIL x0_r1_kept got=%h exp=%h", bus.rd2, 32'h42424242); end
  endtask
  task automatic test_back_to_back();
    bus.we4 = 1'b1;
    bus.wa4 = 5'd3;
    bus.wd4 = 32'hAAAA0001;
    bus.ra1 = 5'd3;
    tick();
    bus.we4 = 1'b0;
    bus.we3 = 1'b1;
    bus.wa3 = 5'd3;
    bus.wd3 = 32'hBBBB0002;
    #1;
    checks++;
    if (bus.rd1 !== 32'hBBBB0002) begin failures++; $display("FAIL b2b_bypass got=%h exp=%h", bus.rd1, 32'hBBBB0002); end
    checks++;
    if (nb.rd1 !== 32'hAAAA0001) begin failures++; $display("FAIL b2b_nobypass got=%h exp=%h", nb.rd1, 32'hAAAA0001); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'hBBBB0002) begin failures++; $display("FAIL b2b_after got=%h exp=%h", bus.rd1, 32'hBBBB0002); end
  endtask
  task automatic test_disabled_port();
    bus.wa3 = 5'd4;
    bus.wd3 = 'x;
    bus.wa4 = 5'd4;
    bus.wd4 = 32'h12345678;
    bus.ra1 = 5'd4;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL disabled_during got=%h exp=%h", bus.rd1, 32'h0); end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL disabled_after got=%h exp=%h", bus.rd1, 32'h0); end
  endtask
  task automatic test_reset_priority();
    reset = 1'b1;
    bus.we3 = 1'b1;
    bus.wa3 = 5'd1;
    bus.wd3 = 32'hDEADBEEF;
    bus.ra1 = 5'd1;
    bus.ra2 = 5'd2;
    #1;
    checks++;
    if (bus.rd1 !== 32'h42424242) begin failures++; $display("FAIL rstpri_no_bypass got=%h exp=%h", bus.rd1, 32'h42424242); end
    tick();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin failures++; $display("FAIL rstpri_r1 got=%h exp=%h", bus.rd1, 32'h0); end
    checks++;
    if (bus.rd2 !== 32'h0) begin failures++; $display("FAIL rstpri_r2 got=%h exp=%h", bus.rd2, 32'h0); end
  endtask
  initial begin
    idle();
    test_reset();
    test_single_write();
    test_dual_write();
    test_collision();
    test_x0();
    test_back_to_back();
    test_disabled_port();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
